// File: rtl/button_event_pkg.sv
// rtl/button_event_pkg.sv - shared types and sizing helper for the button event decoder
package button_event_pkg;

  typedef enum logic [1:0] {
    LOCKOUT,
    IDLE,
    PRESSED,
    REPEATING
  } btn_state_t;

  // Width able to hold max(a, b) - 1, never narrower than one bit
  function automatic int cnt_width(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return ($clog2(m) < 1) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/hold_counter.sv
// rtl/hold_counter.sv - clearable hold-time up-counter with terminal-count compare
module hold_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_clear,
  input  logic             i_inc,
  input  logic [WIDTH-1:0] i_terminal,
  output logic             o_at_terminal
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_inc) begin
      r_count <= r_count + WIDTH'(1);
    end
  end

  assign o_at_terminal = (r_count == i_terminal);

endmodule

// File: rtl/button_event_decoder.sv
// rtl/button_event_decoder.sv - turns a debounced button level into press/release/long/repeat pulses
module button_event_decoder
  import button_event_pkg::*;
#(
  parameter int LONG_PRESS_CYCLES = 50_000_000,
  parameter int REPEAT_CYCLES     = 10_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic debounced_signal,
  input  logic enable,
  output logic press_pulse,
  output logic release_pulse,
  output logic long_press_pulse,
  output logic repeat_pulse,
  output logic held
);

  localparam int CNT_W = cnt_width(LONG_PRESS_CYCLES, REPEAT_CYCLES);
  localparam logic [CNT_W-1:0] LONG_TERM   = CNT_W'(LONG_PRESS_CYCLES - 1);
  localparam logic [CNT_W-1:0] REPEAT_TERM = CNT_W'(REPEAT_CYCLES - 1);

  btn_state_t       r_state;
  logic             w_inc;
  logic             w_clear;
  logic             w_at_term;
  logic [CNT_W-1:0] w_term;

  // The counter only advances while a held button is still short of its threshold;
  // every other case (state change, threshold hit, disable) returns it to zero.
  always_comb begin
    w_inc = 1'b0;
    if (enable && debounced_signal && !w_at_term &&
        (r_state == PRESSED || r_state == REPEATING)) begin
      w_inc = 1'b1;
    end
  end

  assign w_clear = !w_inc;
  assign w_term  = (r_state == REPEATING) ? REPEAT_TERM : LONG_TERM;

  hold_counter #(
    .WIDTH(CNT_W)
  ) u_hold_counter (
    .clk          (clk),
    .rst_n        (reset),
    .i_clear      (w_clear),
    .i_inc        (w_inc),
    .i_terminal   (w_term),
    .o_at_terminal(w_at_term)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state          <= LOCKOUT;
      press_pulse      <= 1'b0;
      release_pulse    <= 1'b0;
      long_press_pulse <= 1'b0;
      repeat_pulse     <= 1'b0;
      held             <= 1'b0;
    end else begin
      press_pulse      <= 1'b0;
      release_pulse    <= 1'b0;
      long_press_pulse <= 1'b0;
      repeat_pulse     <= 1'b0;
      if (!enable) begin
        r_state <= LOCKOUT;
        held    <= 1'b0;
      end else begin
        case (r_state)
          LOCKOUT: begin
            held <= 1'b0;
            if (!debounced_signal) r_state <= IDLE;
          end
          IDLE: begin
            if (debounced_signal) begin
              r_state     <= PRESSED;
              press_pulse <= 1'b1;
              held        <= 1'b1;
            end else begin
              held <= 1'b0;
            end
          end
          PRESSED: begin
            // Release takes priority over a coincident long-press threshold
            if (!debounced_signal) begin
              r_state       <= IDLE;
              release_pulse <= 1'b1;
              held          <= 1'b0;
            end else begin
              held <= 1'b1;
              if (w_at_term) begin
                r_state          <= REPEATING;
                long_press_pulse <= 1'b1;
              end
            end
          end
          REPEATING: begin
            if (!debounced_signal) begin
              r_state       <= IDLE;
              release_pulse <= 1'b1;
              held          <= 1'b0;
            end else begin
              held <= 1'b1;
              if (w_at_term) repeat_pulse <= 1'b1;
            end
          end
          default: begin
            r_state <= LOCKOUT;
            held    <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_button_event_decoder.sv
// tb/tb_button_event_decoder.sv - directed self-checking bench for button_event_decoder
module tb_button_event_decoder;

  logic clk;
  logic reset;
  logic debounced_signal;
  logic enable;
  logic press_pulse;
  logic release_pulse;
  logic long_press_pulse;
  logic repeat_pulse;
  logic held;

  int n_checks = 0;
  int n_errors = 0;

  // Edge-indexed scenario: edge 1 is the first rising edge after reset release.
  typedef struct {
    int   n;
    logic rst_din;
    int   h1a, h1b, h2a, h2b;
    int   en_off;
    int   p1, p2, r1, r2, lg, rp1, rp2;
    int   ha, hb, h2la, h2lb;
  } scen_t;

  scen_t scen [7];

  button_event_decoder #(
    .LONG_PRESS_CYCLES(8),
    .REPEAT_CYCLES    (4)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .debounced_signal(debounced_signal),
    .enable          (enable),
    .press_pulse     (press_pulse),
    .release_pulse   (release_pulse),
    .long_press_pulse(long_press_pulse),
    .repeat_pulse    (repeat_pulse),
    .held            (held)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [4:0] got, input logic [4:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got={prs,rel,lng,rep,held}=%b exp=%b", tag, got, exp);
    end
  endtask

  function automatic logic [4:0] outs();
    return {press_pulse, release_pulse, long_press_pulse, repeat_pulse, held};
  endfunction

  function automatic logic lvl(input scen_t s, input int n);
    return (n >= s.h1a && n <= s.h1b) || (n >= s.h2a && n <= s.h2b);
  endfunction

  function automatic logic [4:0] expv(input scen_t s, input int n);
    logic p, r, l, rp, h;
    p  = (n == s.p1) || (n == s.p2);
    r  = (n == s.r1) || (n == s.r2);
    l  = (n == s.lg);
    rp = (n == s.rp1) || (n == s.rp2);
    h  = (n >= s.ha && n <= s.hb) || (n >= s.h2la && n <= s.h2lb);
    return {p, r, l, rp, h};
  endfunction

  task automatic run(input int idx);
    scen_t s;
    s = scen[idx];
    reset            = 1'b0;
    enable           = 1'b1;
    debounced_signal = s.rst_din;
    @(negedge clk);
    @(negedge clk);
    check($sformatf("s%0d_reset", idx), outs(), 5'b00000);
    reset = 1'b1;
    for (int n = 1; n <= s.n; n++) begin
      debounced_signal = lvl(s, n);
      enable           = (n != s.en_off);
      @(posedge clk);
      #1;
      check($sformatf("s%0d_e%0d", idx, n), outs(), expv(s, n));
    end
  endtask

  initial begin
    reset            = 1'b0;
    enable           = 1'b1;
    debounced_signal = 1'b0;
    //             n   rd h1a h1b h2a h2b en  p1  p2  r1  r2  lg rp1 rp2 ha  hb h2la h2lb
    scen[0] = '{31, 1, 1,  28, 30, 31, -1, 30, -1, -1, -1, -1, -1, -1, 30, 31, -1, -1};
    scen[1] = '{16, 0, 10, 12, -1, -1, -1, 10, -1, 13, -1, -1, -1, -1, 10, 12, -1, -1};
    scen[2] = '{33, 0, 10, 29, -1, -1, -1, 10, -1, 30, -1, 18, 22, 26, 10, 29, -1, -1};
    scen[3] = '{21, 0, 10, 17, -1, -1, -1, 10, -1, 18, -1, -1, -1, -1, 10, 17, -1, -1};
    scen[4] = '{43, 0, 10, 39, 42, 43, 20, 10, 42, -1, -1, 18, -1, -1, 10, 19, 42, 43};
    scen[5] = '{16, 0, 10, 11, 13, 14, -1, 10, 13, 12, 15, -1, -1, -1, 10, 11, 13, 14};
    scen[6] = '{20, 0, 10, 40, -1, -1, -1, 10, -1, -1, -1, 18, -1, -1, 10, 20, -1, -1};

    for (int i = 0; i < 6; i++) run(i);

    // Async reset mid-cycle while REPEATING, then lockout until a low sample
    run(6);
    #3;
    reset = 1'b0;
    #1;
    check("async_rst_clear", outs(), 5'b00000);
    @(negedge clk);
    reset            = 1'b1;
    debounced_signal = 1'b1;
    for (int n = 0; n < 5; n++) begin
      @(posedge clk);
      #1;
      check($sformatf("post_rst_hold_%0d", n), outs(), 5'b00000);
    end
    debounced_signal = 1'b0;
    @(posedge clk);
    #1;
    check("post_rst_low", outs(), 5'b00000);
    debounced_signal = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_press", outs(), 5'b10001);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
